// File: rtl/md_sequencer_if.sv
// -----------------------------------------------------------------------------
// md_sequencer_if
//
// Purpose : bundles the two handshakes of the mul/div sequencer.
//           - issue side  : reservation station -> sequencer (valid/ready, op,
//                           operands, destination tag)
//           - result side : sequencer -> CDB arbiter (request/grant, result,
//                           result tag)
//
// Signals keep their i_/o_ names as seen from the sequencer, so the slave
// modport reads naturally inside md_sequencer.
//
// Modports:
//   slave  : the sequencer (md_sequencer)
//   master : the station / arbiter side (or a testbench)
// -----------------------------------------------------------------------------
interface md_sequencer_if #(
    parameter int RRN_WIDTH = 6
);
    // issue handshake
    logic                 i_valid;
    logic                 o_ready;
    logic [2:0]           i_op;
    logic [31:0]          i_data_1;
    logic [31:0]          i_data_2;
    logic [RRN_WIDTH-1:0] i_rrn;

    // CDB request / result
    logic                 o_get_bus;
    logic                 i_bus_granted;
    logic [31:0]          o_result;
    logic [RRN_WIDTH-1:0] o_rrn;

    modport slave (
        input  i_valid, i_op, i_data_1, i_data_2, i_rrn, i_bus_granted,
        output o_ready, o_get_bus, o_result, o_rrn
    );

    modport master (
        output i_valid, i_op, i_data_1, i_data_2, i_rrn, i_bus_granted,
        input  o_ready, o_get_bus, o_result, o_rrn
    );
endinterface

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
//
// Purpose : multi-cycle controller for the mul/div combo. Accepts one RISC-V M
//           operation at a time from the reservation station, runs it, holds
//           the tagged result and requests the CDB until granted.
//           - MUL/MULH/MULHSU/MULHU : registered operands are presented to an
//             external combinational multiplier for MUL_LATENCY cycles (a
//             multicycle path), then its output is captured.
//           - DIV/DIVU/REM/REMU     : radix-2 restoring divider on operand
//             magnitudes (32 iterations), followed by a FIX cycle that selects
//             quotient/remainder and restores the sign.
//           - Divide by zero and signed overflow are resolved at accept and go
//             straight to DONE.
//
// Parameters:
//   MUL_LATENCY : cycles allotted to the external multiplier path (>= 1)
//   RRN_WIDTH   : rename-register tag width (must match the interface)
//
// Ports:
//   i_clk        : clock
//   i_reset_n    : asynchronous active-low reset
//   i_flush      : synchronous abort of the in-flight operation (top priority)
//   bus          : md_sequencer_if.slave (issue valid/ready + CDB req/grant)
//   o_mul_a/b    : registered multiplier operands
//   o_mul_op     : registered multiplier op (funct3)
//   i_mul_result : external multiplier output for o_mul_op
//   o_busy       : high in every state except IDLE
//
// Configuration macro:
//   MD_DIV_EARLY_OUT_EN : when defined, a non-special divide with
//                         |dividend| < |divisor| finishes at accept
//                         (quotient 0, remainder = original dividend).
// -----------------------------------------------------------------------------
module md_sequencer #(
    parameter int MUL_LATENCY = 2,
    parameter int RRN_WIDTH   = 6
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_flush,
    md_sequencer_if.slave       bus,
    output logic [31:0]         o_mul_a,
    output logic [31:0]         o_mul_b,
    output logic [2:0]          o_mul_op,
    input  logic [31:0]         i_mul_result,
    output logic                o_busy
);

    // Counter must hold both MUL_LATENCY-1 and the 32-iteration divide count.
    localparam int CNT_W = ($clog2(MUL_LATENCY + 1) > 6) ? $clog2(MUL_LATENCY + 1) : 6;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(32);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;

    // operation registers (also feed the multiplier)
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [2:0]           op_q;
    logic [RRN_WIDTH-1:0] rrn_q;

    // divider datapath: dvd_q shifts the dividend out and the quotient in
    logic [31:0]          dvd_q;
    logic [31:0]          dvs_q;
    logic [32:0]          rem_q;
    logic                 q_neg_q;
    logic                 r_neg_q;

    // registered outputs
    logic [31:0]          result_q;
    logic                 ready_q;
    logic                 get_bus_q;
    logic                 busy_q;

    // -------------------------------------------------------------------------
    // Accept-time decode of the incoming divide
    // -------------------------------------------------------------------------
    logic        in_signed;
    logic        in_neg_1;
    logic        in_neg_2;
    logic [31:0] in_mag_1;
    logic [31:0] in_mag_2;
    logic        in_div_zero;
    logic        in_div_ovf;
    logic        in_early;
    logic        in_special;
    logic [31:0] in_special_res;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        in_signed      = 1'b0;
        in_neg_1       = 1'b0;
        in_neg_2       = 1'b0;
        in_mag_1       = bus.i_data_1;
        in_mag_2       = bus.i_data_2;
        in_div_zero    = 1'b0;
        in_div_ovf     = 1'b0;
        in_early       = 1'b0;
        in_special_res = 32'h0;

        // DIV (4) and REM (6) are the signed divides: funct3[0] clear.
        in_signed = ~bus.i_op[0];
        in_neg_1  = in_signed & bus.i_data_1[31];
        in_neg_2  = in_signed & bus.i_data_2[31];
        if (in_neg_1) in_mag_1 = -bus.i_data_1;
        if (in_neg_2) in_mag_2 = -bus.i_data_2;

        in_div_zero = (bus.i_data_2 == 32'h0);
        in_div_ovf  = in_signed && (bus.i_data_1 == 32'h8000_0000)
                                && (bus.i_data_2 == 32'hFFFF_FFFF);
`ifdef MD_DIV_EARLY_OUT_EN
        in_early = (in_mag_1 < in_mag_2);
`else
        in_early = 1'b0;
`endif

        // funct3[1] set selects the remainder flavour (REM/REMU).
        if (in_div_zero)
            in_special_res = bus.i_op[1] ? bus.i_data_1 : 32'hFFFF_FFFF;
        else if (in_div_ovf)
            in_special_res = bus.i_op[1] ? 32'h0 : 32'h8000_0000;
        else
            in_special_res = bus.i_op[1] ? bus.i_data_1 : 32'h0;
    end

    assign in_special = in_div_zero | in_div_ovf | in_early;

    // -------------------------------------------------------------------------
    // One restoring-division step and the final sign fix-up
    // -------------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic        sub_ok;
    logic [31:0] fix_sel;
    logic        fix_neg;
    logic [31:0] fix_val;

    always_comb begin
        rem_shift = {rem_q[31:0], dvd_q[31]};
        sub_ok    = (rem_shift >= {1'b0, dvs_q});

        fix_sel = op_q[1] ? rem_q[31:0] : dvd_q;
        fix_neg = op_q[1] ? r_neg_q : q_neg_q;
        fix_val = fix_neg ? -fix_sel : fix_sel;
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rrn_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            get_bus_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (i_flush) begin
            // Abort wins over grant and accept; any held result is dropped.
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            get_bus_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        a_q     <= bus.i_data_1;
                        b_q     <= bus.i_data_2;
                        op_q    <= bus.i_op;
                        rrn_q   <= bus.i_rrn;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!bus.i_op[2]) begin
                            count <= MUL_CNT_INIT;
                            state <= ST_MUL;
                        end else if (in_special) begin
                            result_q  <= in_special_res;
                            get_bus_q <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            dvd_q   <= in_mag_1;
                            dvs_q   <= in_mag_2;
                            rem_q   <= '0;
                            q_neg_q <= in_neg_1 ^ in_neg_2;
                            r_neg_q <= in_neg_1;
                            count   <= DIV_CNT_INIT;
                            state   <= ST_DIV;
                        end
                    end
                end

                ST_MUL: begin
                    // Operands have been stable since accept; the multiplier
                    // output is trusted only once the window has elapsed.
                    if (count == '0) begin
                        result_q  <= i_mul_result;
                        get_bus_q <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                ST_DIV: begin
                    // 32 iterations while count runs 32..1, then hand off to
                    // FIX once the counter has drained.
                    if (count != '0) begin
                        rem_q <= sub_ok ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                        dvd_q <= {dvd_q[30:0], sub_ok};
                        count <= count - 1'b1;
                    end else begin
                        state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    result_q  <= fix_val;
                    get_bus_q <= 1'b1;
                    state     <= ST_DONE;
                end

                ST_DONE: begin
                    if (bus.i_bus_granted) begin
                        get_bus_q <= 1'b0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    ready_q   <= 1'b1;
                    get_bus_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.o_ready   = ready_q;
    assign bus.o_get_bus = get_bus_q;
    assign bus.o_result  = result_q;
    assign bus.o_rrn     = rrn_q;
    assign o_mul_a       = a_q;
    assign o_mul_b       = b_q;
    assign o_mul_op      = op_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed bench for md_sequencer (MUL_LATENCY = 2, RRN_WIDTH = 6). Provides a
// behavioural RISC-V multiplier on o_mul_*, drives the issue and grant
// handshakes, and checks latency, result, tag and handshake state against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_md_sequencer;

    localparam int RRN_W = 6;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_op;
    logic [31:0] mul_result;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    md_sequencer_if #(.RRN_WIDTH(RRN_W)) bus ();

    md_sequencer #(
        .MUL_LATENCY(2),
        .RRN_WIDTH  (RRN_W)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_flush     (flush),
        .bus         (bus),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .o_mul_op    (mul_op),
        .i_mul_result(mul_result),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational multiplier (RISC-V semantics)
    logic [63:0] sa, sb, ua, ub, p_ss, p_su, p_uu;
    always_comb begin
        sa   = {{32{mul_a[31]}}, mul_a};
        sb   = {{32{mul_b[31]}}, mul_b};
        ua   = {32'h0, mul_a};
        ub   = {32'h0, mul_b};
        p_ss = sa * sb;
        p_su = sa * ub;
        p_uu = ua * ub;
        case (mul_op[1:0])
            2'd0:    mul_result = p_ss[31:0];
            2'd1:    mul_result = p_ss[63:32];
            2'd2:    mul_result = p_su[63:32];
            default: mul_result = p_uu[63:32];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation; returns #1 after the accept edge E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [RRN_W-1:0] tag);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_op     = op;
        bus.i_data_1 = d1;
        bus.i_data_2 = d2;
        bus.i_rrn    = tag;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
    endtask

    // Count edges after E0 until o_get_bus is seen high (bounded).
    task automatic wait_bus(input string name, input int exp_lat);
        int n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.o_get_bus) break;
        end
        check({name, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    // One-cycle grant; checks o_ready in the cycle after G.
    task automatic grant(input string name);
        @(negedge clk);
        bus.i_bus_granted = 1'b1;
        @(posedge clk);
        #1;
        bus.i_bus_granted = 1'b0;
        check({name, "_rdy_after_g"}, 32'(bus.o_ready), 32'd1);
        check({name, "_bus_after_g"}, 32'(bus.o_get_bus), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [RRN_W-1:0] tag,
                          input int lat, input logic [31:0] exp_res);
        issue(op, d1, d2, tag);
        wait_bus(name, lat);
        check({name, "_res"}, bus.o_result, exp_res);
        check({name, "_rrn"}, 32'(bus.o_rrn), 32'(tag));
        grant(name);
    endtask

`ifdef MD_DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif

    initial begin
        logic seen;

        rst_n             = 1'b0;
        flush             = 1'b0;
        bus.i_valid       = 1'b0;
        bus.i_op          = 3'd0;
        bus.i_data_1      = 32'h0;
        bus.i_data_2      = 32'h0;
        bus.i_rrn         = '0;
        bus.i_bus_granted = 1'b0;

        // ---- reset values -------------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   32'(bus.o_ready),   32'd1);
        check("rst_get_bus", 32'(bus.o_get_bus), 32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_result",  bus.o_result,       32'h0);
        check("rst_rrn",     32'(bus.o_rrn),     32'd0);
        check("rst_mul_a",   mul_a,              32'h0);
        check("rst_mul_b",   mul_b,              32'h0);
        check("rst_mul_op",  32'(mul_op),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- async reset in the middle of a divide -----------------------
        issue(3'd5, 32'd100, 32'd7, 6'd3);
        repeat (5) @(posedge clk);
        check("middiv_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready",  32'(bus.o_ready), 32'd1);
        check("arst_busy",   32'(busy),        32'd0);
        check("arst_mul_a",  mul_a,            32'h0);
        check("arst_rrn",    32'(bus.o_rrn),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_get_bus || busy) seen = 1'b1;
        end
        check("arst_no_result", 32'(seen), 32'd0);

        // ---- basic MUL ----------------------------------------------------
        issue(3'd0, 32'd7, 32'd6, 6'd5);
        check("mul_ready_low", 32'(bus.o_ready), 32'd0);
        check("mul_a_reg",     mul_a,            32'd7);
        check("mul_b_reg",     mul_b,            32'd6);
        wait_bus("mul7x6", 2);
        check("mul7x6_res", bus.o_result,   32'd42);
        check("mul7x6_rrn", 32'(bus.o_rrn), 32'd5);
        grant("mul7x6");

        run_op("mulh",  3'd1, 32'hFFFF_FFFE, 32'd3, 6'd6, 2, 32'hFFFF_FFFF);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 6'd7, 2, 32'h0000_0001);

        // ---- iterative divides -------------------------------------------
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 6'd1, 34, 32'hFFFF_FFFD);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 6'd2, 34, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 6'd3, 34, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 6'd4, 34, 32'd2);

        // ---- special cases -----------------------------------------------
        run_op("div_5_0",   3'd4, 32'd5,         32'd0,         6'd10, 1, 32'hFFFF_FFFF);
        run_op("remu_5_0",  3'd7, 32'd5,         32'd0,         6'd11, 1, 32'd5);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 1, 32'h8000_0000);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 1, 32'h0);

        // ---- grant stall, then accept at G+1 ------------------------------
        issue(3'd0, 32'd3, 32'd4, 6'd20);
        wait_bus("stall", 2);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("stall_res",   bus.o_result,       32'd12);
            check("stall_rrn",   32'(bus.o_rrn),     32'd20);
            check("stall_ready", 32'(bus.o_ready),   32'd0);
            check("stall_bus",   32'(bus.o_get_bus), 32'd1);
        end
        // grant and a new op presented together: op must wait for G+1
        @(negedge clk);
        bus.i_bus_granted = 1'b1;
        bus.i_valid       = 1'b1;
        bus.i_op          = 3'd0;
        bus.i_data_1      = 32'd9;
        bus.i_data_2      = 32'd9;
        bus.i_rrn         = 6'd21;
        @(posedge clk);                 // G
        #1;
        bus.i_bus_granted = 1'b0;
        check("g_ready",   32'(bus.o_ready), 32'd1);
        check("g_busy",    32'(busy),        32'd0);
        @(posedge clk);                 // G+1 : accept
        #1;
        bus.i_valid = 1'b0;
        check("g1_busy",   32'(busy),        32'd1);
        check("g1_mul_a",  mul_a,            32'd9);
        wait_bus("g1_mul", 2);
        check("g1_res",    bus.o_result,     32'd81);
        check("g1_rrn",    32'(bus.o_rrn),   32'd21);
        grant("g1_mul");

        // ---- flush mid-divide with a competing valid ----------------------
        issue(3'd5, 32'd100, 32'd7, 6'd30);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush        = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_op     = 3'd0;
        bus.i_data_1 = 32'd2;
        bus.i_data_2 = 32'd3;
        bus.i_rrn    = 6'd31;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        check("flush_busy",  32'(busy),        32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_get_bus || busy) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);

        // ---- flush together with grant in DONE ----------------------------
        issue(3'd4, 32'd5, 32'd0, 6'd40);
        wait_bus("fg", 1);
        @(negedge clk);
        flush             = 1'b1;
        bus.i_bus_granted = 1'b1;
        @(posedge clk);
        #1;
        flush             = 1'b0;
        bus.i_bus_granted = 1'b0;
        check("fg_bus",   32'(bus.o_get_bus), 32'd0);
        check("fg_ready", 32'(bus.o_ready),   32'd1);
        check("fg_busy",  32'(busy),          32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("fg_bus_later", 32'(bus.o_get_bus), 32'd0);

        // ---- early-out candidates ----------------------------------------
        run_op("divu_3_10", 3'd5, 32'd3,         32'd10, 6'd50, EARLY_LAT, 32'd0);
        run_op("rem_m3_10", 3'd6, 32'hFFFF_FFFD, 32'd10, 6'd51, EARLY_LAT, 32'hFFFF_FFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
